// File: rtl/spi_prog_master.sv
// Host-side programmer for the processor's serial load/run port: shifts {data, addr} frames
// LSB first under the cache chip-selects and holds the run encoding. Optional run watchdog: RUN_TIMEOUT_EN.
module spi_prog_master #(
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       proc_done_in,
    output logic [1:0] sel_out,
    output logic       mosi_out,
    output logic       busy_out,
    output logic       run_done_out,
    output logic       run_timeout_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_RUN
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic             r_mosi;
    logic [10:0]      r_shift;
    logic [3:0]       r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_ack;
    logic             r_run_done;
    logic             w_run_complete;
    logic             w_run_expired;

    assign w_run_complete = r_ack && proc_done_in;

`ifdef RUN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_run_timeout;

    assign w_run_expired   = (r_state == S_RUN) && (r_to_cnt == TO_LIMIT);
    assign run_timeout_out = r_run_timeout;

    // Counts cycles spent in RUN; cleared whenever the block is anywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_run_timeout <= 1'b0;
        end else begin
            r_run_timeout <= (r_state == S_RUN) && !w_run_complete && w_run_expired;
            if (r_state != S_RUN) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end
`else
    assign w_run_expired   = 1'b0;
    assign run_timeout_out = 1'b0;
`endif

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy_out     = ~cmd_ready;
    assign mosi_out     = r_mosi;
    assign run_done_out = r_run_done;

    // Run is released in the very cycle the processor reports idle again, so its
    // idle state never sees the run encoding on the following edge.
    always_comb begin
        sel_out = r_sel;
        if (r_state == S_RUN) begin
            sel_out = (w_run_complete || w_run_expired) ? 2'b00 : 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'b00;
            r_mosi     <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ack      <= 1'b0;
            r_run_done <= 1'b0;
        end else begin
            r_run_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00, 2'b01: begin
                                r_state   <= S_SHIFT;
                                r_sel     <= (cmd_op == 2'b00) ? 2'b01 : 2'b10;
                                r_mosi    <= cmd_addr[0];
                                r_shift   <= {cmd_data, cmd_addr[3:1]};
                                r_bit_cnt <= '0;
                            end
                            2'b10: begin
                                r_state <= S_RUN;
                                r_ack   <= 1'b0;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == 4'd11) begin
                        r_state   <= S_GAP;
                        r_sel     <= 2'b00;
                        r_mosi    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_mosi    <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[10:1]};
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!proc_done_in) begin
                        r_ack <= 1'b1;
                    end
                    if (w_run_complete || w_run_expired) begin
                        r_state    <= S_IDLE;
                        r_run_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prog_master.sv
// Bench for spi_prog_master: a small processor-side model captures frames and runs;
// a scoreboard queue holds the cache writes expected from each accepted command.
module tb_spi_prog_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       proc_done_in;
    logic [1:0] sel_out;
    logic       mosi_out;
    logic       busy_out;
    logic       run_done_out;
    logic       run_timeout_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_prog_master #(
        .GAP_CYCLES    (1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .proc_done_in   (proc_done_in),
        .sel_out        (sel_out),
        .mosi_out       (mosi_out),
        .busy_out       (busy_out),
        .run_done_out   (run_done_out),
        .run_timeout_out(run_timeout_out)
    );

    // Processor-side model: right-shifting 12-bit buffer, commit on the first deselected
    // cycle, and an execute phase that holds done low for m_plen cycles.
    logic [11:0] m_buff     = '0;
    logic        m_in_frame = 1'b0;
    logic [1:0]  m_kind     = 2'b00;
    logic [7:0]  m_icache [16];
    logic [7:0]  m_dcache [16];
    int          m_commits  = 0;
    logic [1:0]  m_last_sel = 2'b00;
    logic [3:0]  m_last_addr = '0;
    logic [7:0]  m_last_data = '0;
    int          m_run_entries = 0;
    int          m_pcnt = 0;
    int          m_plen = 5;
    bit          m_stuck = 1'b0;

    assign proc_done_in = m_stuck ? 1'b0 : (m_pcnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            m_in_frame <= 1'b0;
            m_buff     <= '0;
            m_pcnt     <= 0;
        end else begin
            if (sel_out == 2'b01 || sel_out == 2'b10) begin
                m_buff     <= {mosi_out, m_buff[11:1]};
                m_in_frame <= 1'b1;
                m_kind     <= sel_out;
            end else if (m_in_frame) begin
                m_in_frame  <= 1'b0;
                m_commits   <= m_commits + 1;
                m_last_sel  <= m_kind;
                m_last_addr <= m_buff[3:0];
                m_last_data <= m_buff[11:4];
                if (m_kind == 2'b01) m_icache[m_buff[3:0]] <= m_buff[11:4];
                else                 m_dcache[m_buff[3:0]] <= m_buff[11:4];
            end
            if (m_pcnt != 0) begin
                m_pcnt <= m_pcnt - 1;
            end else if (sel_out == 2'b11) begin
                m_pcnt        <= m_plen;
                m_run_entries <= m_run_entries + 1;
            end
        end
    end

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] addr;
        logic [7:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [1:0]  exp_sel;
        logic [11:0] exp_seq;   // bit k = k-th bit seen on mosi
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                         input bit push);
        sb_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        if (push) begin
            e.sel  = (op == 2'b00) ? 2'b01 : 2'b10;
            e.addr = addr;
            e.data = data;
            sb_q.push_back(e);
        end
        check("offer_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Called just after the accepting edge; follows the frame until cmd_ready returns.
    task automatic check_frame(input string name, input logic [1:0] exp_sel, input logic [11:0] exp_seq);
        int          sel_hits  = 0;
        int          busy_hits = 0;
        int          ready_n   = 0;
        int          c0;
        logic [11:0] seq       = '0;
        logic [2:0]  gap       = 3'b111;
        sb_t         e;
        c0 = m_commits;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n <= 12) begin
                if (sel_out == exp_sel) sel_hits++;
                seq[n-1] = mosi_out;
            end
            if (n == 13) gap = {sel_out, mosi_out};
            if (busy_out) busy_hits++;
            if (cmd_ready) begin
                ready_n = n;
                break;
            end
        end
        check({name, "_sel"},   sel_hits, 12);
        check({name, "_mosi"},  {20'd0, seq}, {20'd0, exp_seq});
        check({name, "_gap"},   {29'd0, gap}, 32'd0);
        check({name, "_ready"}, ready_n, 14);
        check({name, "_busy"},  busy_hits, 13);
        check({name, "_commits"}, m_commits, c0 + 1);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_commit"}, {18'd0, m_last_sel, m_last_addr, m_last_data}, {18'd0, e});
        end
        $display("frame %s: sel=%b seq=%03h ready_at=%0d commit=%b/%h/%h",
                 name, exp_sel, seq, ready_n, m_last_sel, m_last_addr, m_last_data);
    endtask

    // Waits (bounded) for the end of a run; returns the number of cycles sel_out held 11.
    task automatic follow_run(output int hi);
        hi = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (sel_out == 2'b11) hi++;
            else break;
        end
    endtask

    initial begin
        int c0;
        int e0;
        int hi;
        int pulses;

        vecs[0] = '{2'b00, 4'h3, 8'hA5, 2'b01, 12'b1010_0101_0011};
        vecs[1] = '{2'b01, 4'hF, 8'h01, 2'b10, 12'b0000_0001_1111};
        vecs[2] = '{2'b00, 4'h0, 8'hFF, 2'b01, 12'b1111_1111_0000};
        vecs[3] = '{2'b01, 4'h8, 8'h3C, 2'b10, 12'b0011_1100_1000};
        vecs[4] = '{2'b00, 4'hF, 8'h80, 2'b01, 12'b1000_0000_1111};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {26'd0, sel_out, mosi_out, cmd_ready, busy_out, run_done_out},
              {26'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
        check("reset_timeout", {31'd0, run_timeout_out}, 32'd0);
        rst = 1'b0;

        // Table-driven cache writes
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            offer(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1);
            after_edge();
            cmd_valid = 1'b0;
            check_frame($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_seq);
        end
        check("icache3", {24'd0, m_icache[3]}, 32'hA5);
        check("dcache15", {24'd0, m_dcache[15]}, 32'h01);

        // Backpressure: a second command held throughout the first frame
        @(negedge clk);
        offer(2'b00, 4'h6, 8'h5A, 1'b1);
        after_edge();
        offer_hold: begin
            sb_t e;
            cmd_op   = 2'b01;
            cmd_addr = 4'h9;
            cmd_data = 8'hC3;
            e.sel = 2'b10; e.addr = 4'h9; e.data = 8'hC3;
            sb_q.push_back(e);
        end
        check_frame("bp_first", 2'b01, 12'b0101_1010_0110);
        after_edge();
        cmd_valid = 1'b0;
        check_frame("bp_held", 2'b10, 12'b1100_0011_1001);

        // Reserved op: accepted, nothing happens
        c0 = m_commits;
        @(negedge clk);
        offer(2'b11, 4'h1, 8'h22, 1'b0);
        after_edge();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("op11_ready", {31'd0, cmd_ready}, 32'd1);
        check("op11_sel", {30'd0, sel_out}, 32'd0);
        repeat (3) @(negedge clk);
        check("op11_no_commit", m_commits, c0);
        $display("op11: ready=%b sel=%b", cmd_ready, sel_out);

        // Run with the model holding done low for 5 cycles
        e0 = m_run_entries;
        @(negedge clk);
        offer(2'b10, 4'h0, 8'h00, 1'b0);
        after_edge();
        cmd_valid = 1'b0;
        follow_run(hi);
        check("run_sel11_cycles", hi, 6);
        check("run_release", {29'd0, sel_out, proc_done_in}, {29'd0, 2'b00, 1'b1});
        check("run_done_early", {31'd0, run_done_out}, 32'd0);
        @(negedge clk);
        check("run_done_pulse", {30'd0, run_done_out, run_timeout_out}, {30'd0, 2'b10});
        check("run_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("run_done_single", {31'd0, run_done_out}, 32'd0);
        repeat (4) @(negedge clk);
        check("run_entries", m_run_entries, e0 + 1);
        $display("run: sel11_cycles=%0d entries=%0d", hi, m_run_entries - e0);

        // Reset at bit 6 of a frame
        c0 = m_commits;
        @(negedge clk);
        offer(2'b00, 4'h2, 8'h3C, 1'b0);
        after_edge();
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_pre", {29'd0, sel_out, mosi_out}, {29'd0, 3'b011});
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort", {29'd0, sel_out, mosi_out, cmd_ready}, {29'd0, 2'b00, 1'b0, 1'b1});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_commit", m_commits, c0);
        $display("reset: aborted frame dropped, commits=%0d", m_commits);
        offer(2'b01, 4'h4, 8'hE1, 1'b1);
        after_edge();
        cmd_valid = 1'b0;
        check_frame("after_rst", 2'b10, 12'b1110_0001_0100);

`ifdef RUN_TIMEOUT_EN
        // Watchdog: processor never reports done
        m_stuck = 1'b1;
        @(negedge clk);
        offer(2'b10, 4'h0, 8'h00, 1'b0);
        after_edge();
        cmd_valid = 1'b0;
        follow_run(hi);
        check("to_sel11_cycles", hi, 8);
        check("to_release", {30'd0, sel_out}, 32'd0);
        @(negedge clk);
        check("to_pulses", {30'd0, run_done_out, run_timeout_out}, {30'd0, 2'b11});
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (run_done_out || run_timeout_out) pulses++;
        end
        check("to_single", pulses, 0);
        $display("timeout: sel11_cycles=%0d", hi);
        m_stuck = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_prog_master.md
Name: spi_prog_master

Overview:
- Master end of the processor's serial load/run interface: the programmer that drives the processor's mode lines (uio_in[1:0]) and mosi (uio_in[2]), and watches its done flag (uio_out[3]).
- Accepts host commands one at a time:
  - instruction write: serialises a 12-bit {data[7:0], addr[3:0]} frame into the instruction cache;
  - data write: serialises the same frame into the data cache;
  - run: holds the run encoding until the program completes.
- Sits in the FPGA demo/test harness and any host-side bridge, on the processor's clock.

Parameters:
- GAP_CYCLES, 1, idle cycles with sel=00 after each frame; minimum 1. The processor commits the write in the first deselected cycle.
- TIMEOUT_CYCLES, 1024, run watchdog limit in cycles. Used only with RUN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, same clock as the processor.
- rst  input  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  2  00 instr write, 01 data write, 10 run, 11 reserved.
- cmd_addr  input  4  cache address.
- cmd_data  input  8  cache data.
- proc_done_in  input  1  processor done flag; high when the processor FSM is idle.
- sel_out  output  2  processor mode lines.
  - 00 idle.
  - 01 instr chip-select.
  - 10 data chip-select.
  - 11 run.
- mosi_out  output  1  serial data.
- busy_out  output  1  equals ~cmd_ready.
- run_done_out  output  1  one-cycle pulse when a run ends.
- run_timeout_out  output  1  one-cycle pulse when the watchdog aborts a run. Tied 0 without the macro.

Behaviour:
- Reset values: state IDLE, sel_out=00, mosi_out=0, cmd_ready=1, busy_out=0, run_done_out=0, run_timeout_out=0, all counters 0.
- Reset mid-operation aborts immediately. Outputs take their reset values at the next edge. No partial frame is completed.
- States: IDLE, SHIFT, GAP, RUN.
- IDLE:
  - cmd_valid & cmd_ready accepts the command and latches op/addr/data.
  - op 00/01: frame = {data, addr}; next state SHIFT.
  - op 10: next state RUN.
  - op 11: accepted, no action, stays IDLE.
- SHIFT:
  - Lasts exactly 12 cycles, with bit counter 0..11.
  - sel_out=01 (instr) or 10 (data), registered.
  - mosi_out = frame[counter], LSB first: addr[0] first, data[7] last. This matches the processor's right-shifting 12-bit buffer, which ends with buff[3:0]=addr and buff[11:4]=data.
  - After the 12th bit the next state is GAP.
- GAP:
  - sel_out=00, mosi_out=0 for GAP_CYCLES cycles, then IDLE.
  - cmd_ready rises on the first IDLE cycle: 12+GAP_CYCLES+1 cycles after acceptance.
- RUN:
  - Internal flag ack is cleared on entry and set on any cycle with proc_done_in=0.
  - sel_out = 11 while !(ack & proc_done_in). In RUN this term is combinational.
  - Once ack & proc_done_in, sel_out=00 in that same cycle. This prevents the processor's idle state from re-entering execute on the next edge.
  - Next state IDLE; run_done_out pulses in the first IDLE cycle.
- Commands offered while busy are not accepted. cmd_ready=0 and the inputs are ignored.
- Back-to-back commands: a new command can be accepted on the first IDLE cycle. Minimum frame-to-frame spacing is 12+GAP_CYCLES+1 cycles.
- Bit counter is 4 bits wide. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates.

Optional Feature:
- Macro RUN_TIMEOUT_EN.
- Defined:
  - A counter increments every RUN cycle.
  - On reaching TIMEOUT_CYCLES without completion, sel_out=00 that cycle and the state goes to IDLE.
  - run_done_out and run_timeout_out both pulse in the first IDLE cycle.
  - Dropping run makes the processor leave execute.
- Not defined: no counter; RUN waits indefinitely; run_timeout_out is constant 0.

Test Plan:
- Instr write, addr=0x3 data=0xA5:
  - sel_out=01 for 12 cycles, mosi sequence 1,1,0,0,1,0,1,0,0,1,0,1;
  - then sel_out=00 for 1 cycle;
  - cmd_ready high 14 cycles after acceptance;
  - with the processor attached, icache[3]=0xA5.
- Data write, addr=0xF data=0x01: sel_out=10 for 12 cycles, mosi 1,1,1,1,1,0,0,0,0,0,0,0; dcache[15]=0x01.
- Run with a model holding proc_done_in low for 5 cycles:
  - sel_out=11 from acceptance through the last low cycle;
  - sel_out=00 in the first cycle proc_done_in is high;
  - run_done_out is a single pulse next cycle;
  - the model sees no second run entry.
- Backpressure and reserved op:
  - cmd_valid held during SHIFT is not accepted until IDLE; the frame completes unaltered.
  - op=11 is accepted in 1 cycle and sel_out stays 00.
- rst asserted at bit 6 of a frame: next cycle sel_out=00, mosi_out=0, cmd_ready=1; the following command shifts from bit 0.
- With RUN_TIMEOUT_EN, TIMEOUT_CYCLES=8, proc_done_in stuck low: sel_out=11 for 8 cycles, then 00; run_done_out and run_timeout_out pulse together once.
